four_bit_adder: RTL and testbench
=================================

Name: four_bit_adder

Overview:
- Registered 4-bit unsigned ripple-carry adder: a + b + cin -> 4-bit sum s plus carry-out cout.
- Leaf arithmetic block on the single system clock domain.
- Built from a chain of full-adder cells with one output register stage.
- Qualified by a simple valid strobe.

Parameters:
- WIDTH, 4, operand/sum width. Only 4 is required to be supported; any other value is rejected at elaboration.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry-in; tie 0 for plain a+b
- in_valid  input  1  operands valid this cycle
- s  output  4  registered sum bits [3:0]
- cout  output  1  registered carry-out (bit 4 of the result)
- out_valid  output  1  registered; high for one cycle per accepted operand set

Behaviour:
- Combinational core:
  - Four full-adder cells; cell i computes sum_i = a[i]^b[i]^c_i and c_(i+1) = a[i]&b[i] | c_i&(a[i]^b[i]).
  - c_0 = cin; cout_next = c_4.
  - Result {cout_next, sum} equals a + b + cin exactly, range 0..31.
- Register stage, on rising clk:
  - If in_valid = 1: s <= sum, cout <= cout_next.
  - If in_valid = 0: s and cout hold their previous values.
  - out_valid <= in_valid every cycle.
- Latency: exactly 1 clock from in_valid high to s/cout/out_valid updated. Throughput is one operand set per clock; back-to-back in_valid is legal.
- Reset:
  - rst_n low asynchronously forces s = 4'b0000, cout = 0, out_valid = 0, regardless of clk.
  - Outputs remain at these values while rst_n is low.
  - On release, the first capture occurs at the first rising clk with in_valid high.
  - Reset asserted mid-stream discards any pending result. No residual out_valid pulse after release.
- Wrap-around: results above 15 wrap in s with cout = 1 (e.g. 15+1 -> s=0000, cout=1). No saturation.
- Boundary cases:
  - 0+0+0 -> s=0, cout=0.
  - 15+15+1 -> s=1111, cout=1 (max result 31).
- Inputs are assumed synchronous to clk. No input registers are required.
- The X/Z behaviour of unknown inputs is not specified.

Optional Feature:
- Macro: FOUR_BIT_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside s with the same enable and reset behaviour (reset value 0).
  - ovf = c_3 ^ c_4, i.e. two's-complement signed overflow of a + b + cin.
- Undefined:
  - Port ovf does not exist; no overflow logic is generated.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 100 ns with a=0, b=0 -> s=0000, cout=0, out_valid=0. Assert rst_n=0 asynchronously mid-cycle after a nonzero result -> outputs clear immediately, without waiting for a clock edge.
- Basic add: a=0110, b=0011, cin=0, in_valid=1 -> next cycle s=1001, cout=0, out_valid=1. With OVF_EN: ovf=1.
- Carry-out: a=1011, b=0110, cin=0 -> s=0001, cout=1. With OVF_EN: ovf=0.
- Carry-in and max: a=1111, b=1111, cin=1 -> s=1111, cout=1. Also a=1111, b=0000, cin=1 -> s=0000, cout=1.
- Hold: apply a=0110, b=0011 valid, then change a/b with in_valid=0 for 3 cycles -> s stays 1001, cout stays 0, out_valid=0 on those cycles.
- Exhaustive: all 512 (a, b, cin) combinations back-to-back with in_valid=1 -> each result equals a+b+cin one cycle later, out_valid high continuously.

Source files
------------

// File: rtl/four_bit_adder.sv
// four_bit_adder: registered ripple-carry adder a + b + cin -> {cout, s}, with valid strobe.
// Optional signed-overflow output ovf enabled by defining FOUR_BIT_ADDER_OVF_EN.
module four_bit_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
`ifdef FOUR_BIT_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid
);
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_out_valid;
   if (WIDTH != 4) begin : g_bad_width
      $error("four_bit_adder supports only WIDTH = 4");
   end
   assign w_c[0] = cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign w_sum[i]  = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end
`ifdef FOUR_BIT_ADDER_OVF_EN
   logic w_ovf;
   logic r_ovf;
   assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];
   // Overflow flag captured with the same enable and reset as the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ovf <= 1'b0;
      else if (in_valid) r_ovf <= w_ovf;
   end
   assign ovf = r_ovf;
`endif
   // Capture the result on accepted operands; out_valid follows in_valid by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH];
         end
      end
   end
   assign s         = r_s;
   assign cout      = r_cout;
   assign out_valid = r_out_valid;
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed vector table plus reset, hold and exhaustive sequences.
module tb_four_bit_adder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       in_valid;
   logic [3:0] s;
   logic       cout;
   logic       out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
   logic       ovf;
`endif
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic       v;
      logic [3:0] es;
      logic       ec;
      logic       eo;
      logic       ev;
   } vec_t;
   vec_t vt[11];

   four_bit_adder dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
      .s(s), .cout(cout),
`ifdef FOUR_BIT_ADDER_OVF_EN
      .ovf(ovf),
`endif
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input int es, input int ec, input int eo, input int ev);
      chk({tag, ".s"}, int'(s), es);
      chk({tag, ".cout"}, int'(cout), ec);
      chk({tag, ".out_valid"}, int'(out_valid), ev);
`ifdef FOUR_BIT_ADDER_OVF_EN
      chk({tag, ".ovf"}, int'(ovf), eo);
`endif
   endtask

   task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic tv);
      @(negedge clk);
      a = ta;
      b = tb;
      cin = tc;
      in_valid = tv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ua, ub, sa, sb, r;
      vt[0]  = '{4'b0110, 4'b0011, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1};
      vt[1]  = '{4'b1011, 4'b0110, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1};
      vt[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
      vt[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
      vt[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
      vt[5]  = '{4'b0110, 4'b0011, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1};
      vt[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0};
      vt[7]  = '{4'b0101, 4'b1010, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{4'b1000, 4'b0001, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{4'b1000, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1};
      vt[10] = '{4'b0111, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1};

      // reset held with busy inputs: outputs must stay cleared
      rst_n = 1'b0;
      a = 4'd5;
      b = 4'd5;
      cin = 1'b1;
      in_valid = 1'b1;
      #50;
      chk_out("reset_mid", 0, 0, 0, 0);
      #49;
      chk_out("reset_end", 0, 0, 0, 0);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b1;
      apply(4'd0, 4'd0, 1'b0, 1'b0);
      chk_out("post_release", 0, 0, 0, 0);

      for (int i = 0; i < 11; i++) begin
         apply(vt[i].a, vt[i].b, vt[i].cin, vt[i].v);
         chk_out($sformatf("vec%0d", i), vt[i].es, vt[i].ec, vt[i].eo, vt[i].ev);
      end

      // asynchronous reset mid-cycle after a nonzero result, with operands pending
      apply(4'b1111, 4'b1111, 1'b1, 1'b1);
      chk_out("pre_async", 15, 1, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_clear", 0, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_out("async_release", 0, 0, 0, 0);

      // exhaustive back-to-back sweep
      for (int i = 0; i < 512; i++) begin
         ua = i & 15;
         ub = (i >> 4) & 15;
         apply(4'(ua), 4'(ub), 1'(i >> 8), 1'b1);
         sa = ua > 7 ? ua - 16 : ua;
         sb = ub > 7 ? ub - 16 : ub;
         r = sa + sb + (i >> 8);
         chk_out($sformatf("ex%0d", i), (ua + ub + (i >> 8)) % 16, (ua + ub + (i >> 8)) / 16,
                 (r > 7 || r < -8) ? 1 : 0, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
